// File: rtl/pwm_ramp_ctrl.sv
// Soft-start slew controller: ramps three PWM duties toward CPU targets and masters the PWM register bus.
// Latency: CPU writes/reads land on the next posedge; a tick's sweep starts 1 cycle after tick_pend is set.
// Backpressure: none; ticks arriving while one is already pending are dropped, and a kick waits for the sweep to end.
module pwm_ramp_ctrl #(
    parameter int DUTY_W   = 10,
    parameter int TICK_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs,
    input  logic [3:0]  addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [15:0] d_in,
    output logic [15:0] d_out,
    output logic        pwm_cs,
    output logic        pwm_wr,
    output logic [3:0]  pwm_addr,
    output logic [15:0] pwm_data,
    output logic        busy
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
    localparam int PAD_W = 16 - DUTY_W;

    typedef enum logic [2:0] {S_IDLE, S_KICK, S_EVAL, S_WRITE, S_GAP} state_t;

    state_t              state;
    logic [DUTY_W-1:0]   target [3];
    logic [DUTY_W-1:0]   cur    [3];
    logic [DUTY_W-1:0]   step;
    logic [CNT_W-1:0]    tick_cnt;
    logic                enable;
    logic                kick_pend;
    logic                tick_pend;
    logic                force_wr;
    logic [1:0]          ch;

    logic [DUTY_W-1:0]   cur_sel;
    logic [DUTY_W-1:0]   tgt_sel;
    logic [DUTY_W-1:0]   next_duty;
    logic                unused_dat;

    assign unused_dat = ^d_in[15:DUTY_W];

    // Saturating step toward the target; step==0 means jump straight there.
    always_comb begin
        cur_sel = '0;
        tgt_sel = '0;
        case (ch)
            2'd0:    begin cur_sel = cur[0]; tgt_sel = target[0]; end
            2'd1:    begin cur_sel = cur[1]; tgt_sel = target[1]; end
            2'd2:    begin cur_sel = cur[2]; tgt_sel = target[2]; end
            default: ;
        endcase
        next_duty = tgt_sel;
        if (step != '0) begin
            if (tgt_sel > cur_sel) begin
                if (tgt_sel - cur_sel > step) next_duty = cur_sel + step;
            end else if (cur_sel - tgt_sel > step) begin
                next_duty = cur_sel - step;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            for (int i = 0; i < 3; i++) begin
                target[i] <= '0;
                cur[i]    <= '0;
            end
            step      <= DUTY_W'(1);
            tick_cnt  <= '0;
            enable    <= 1'b0;
            kick_pend <= 1'b0;
            tick_pend <= 1'b0;
            force_wr  <= 1'b0;
            ch        <= 2'd0;
            pwm_cs    <= 1'b0;
            pwm_wr    <= 1'b0;
            pwm_addr  <= 4'd0;
            pwm_data  <= 16'd0;
            busy      <= 1'b0;
        end else begin
            if (!enable || tick_cnt == CNT_MAX) tick_cnt <= '0;
            else                                tick_cnt <= tick_cnt + 1'b1;

            case (state)
                S_IDLE: begin
                    if (kick_pend) begin
                        kick_pend <= 1'b0;
                        force_wr  <= 1'b1;
                        busy      <= 1'b1;
                        pwm_cs    <= 1'b1;
                        pwm_wr    <= 1'b1;
                        pwm_addr  <= 4'd0;
                        pwm_data  <= 16'd0;
                        state     <= S_KICK;
                    end else if (tick_pend) begin
                        tick_pend <= 1'b0;
                        force_wr  <= 1'b0;
                        ch        <= 2'd0;
                        busy      <= 1'b1;
                        state     <= S_EVAL;
                    end
                end
                // ch=3 lets the shared GAP increment wrap to channel 0.
                S_KICK: begin
                    pwm_cs <= 1'b0;
                    pwm_wr <= 1'b0;
                    ch     <= 2'd3;
                    state  <= S_GAP;
                end
                S_EVAL: begin
                    if (next_duty != cur_sel || force_wr) begin
                        for (int i = 0; i < 3; i++)
                            if (ch == 2'(i)) cur[i] <= next_duty;
                        pwm_cs   <= 1'b1;
                        pwm_wr   <= 1'b1;
                        pwm_addr <= {1'b0, ch, 1'b0} + 4'd2;
                        pwm_data <= {{PAD_W{1'b0}}, next_duty};
                        state    <= S_WRITE;
                    end else if (ch == 2'd2) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        ch <= ch + 2'd1;
                    end
                end
                S_WRITE: begin
                    pwm_cs <= 1'b0;
                    pwm_wr <= 1'b0;
                    state  <= S_GAP;
                end
                S_GAP: begin
                    if (ch == 2'd2) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        ch    <= ch + 2'd1;
                        state <= S_EVAL;
                    end
                end
                default: begin
                    pwm_cs <= 1'b0;
                    pwm_wr <= 1'b0;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase

            // CPU and tick sets come after the FSM so a same-cycle request is never lost.
            if (cs && wr) begin
                case (addr)
                    4'h0: begin
                        enable <= d_in[0];
                        if (d_in[1]) kick_pend <= 1'b1;
                    end
                    4'h2:    target[0] <= d_in[DUTY_W-1:0];
                    4'h4:    target[1] <= d_in[DUTY_W-1:0];
                    4'h6:    target[2] <= d_in[DUTY_W-1:0];
                    4'h8:    step      <= d_in[DUTY_W-1:0];
                    default: ;
                endcase
            end
            if (enable && tick_cnt == CNT_MAX) tick_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_out <= 16'd0;
        end else if (cs && rd) begin
            case (addr)
                4'h2:    d_out <= {{PAD_W{1'b0}}, cur[0]};
                4'h4:    d_out <= {{PAD_W{1'b0}}, cur[1]};
                4'h6:    d_out <= {{PAD_W{1'b0}}, cur[2]};
                4'h8:    d_out <= {{PAD_W{1'b0}}, step};
                4'hA:    d_out <= {12'd0, busy, kick_pend, tick_pend, enable};
                default: d_out <= 16'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: cycle-timeline model of sweeps checked on every cycle, plus directed literal cases.
module tb_pwm_ramp_ctrl;

    localparam int TD = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [3:0]  addr = 4'd0;
    logic [15:0] d_in = 16'd0;
    logic [15:0] d_out;
    logic        pwm_cs, pwm_wr, busy;
    logic [3:0]  pwm_addr;
    logic [15:0] pwm_data;

    pwm_ramp_ctrl #(.DUTY_W(10), .TICK_DIV(TD)) dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .addr(addr), .rd(rd), .wr(wr),
        .d_in(d_in), .d_out(d_out), .pwm_cs(pwm_cs), .pwm_wr(pwm_wr),
        .pwm_addr(pwm_addr), .pwm_data(pwm_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;
    bit chk_en = 1'b0;

    int m_cur [3];
    int m_tgt [3];
    int m_step;
    bit exp_wr   [int];
    int exp_adr  [int];
    int exp_dat  [int];
    bit exp_busy [int];
    int obs [$];
    int lit [8];

    // Every cycle after edge N, the bus and busy must match the model's timeline.
    always @(negedge clk) begin
        bit ew, eb;
        if (chk_en) begin
            ew = exp_wr.exists(cyc);
            eb = exp_busy.exists(cyc);
            total++;
            if ({pwm_cs, pwm_wr, busy} !== {ew, ew, eb}) begin
                bad++;
                $display("FAIL bus_ctl cyc=%0d got cs/wr/busy=%b%b%b want %b%b%b",
                         cyc, pwm_cs, pwm_wr, busy, ew, ew, eb);
            end
            if (pwm_cs) obs.push_back(int'({pwm_addr, pwm_data}));
            if (ew) begin
                total++;
                if (pwm_addr !== 4'(exp_adr[cyc]) || pwm_data !== 16'(exp_dat[cyc])) begin
                    bad++;
                    $display("FAIL bus_dat cyc=%0d got addr=%h data=%0d want addr=%h data=%0d",
                             cyc, pwm_addr, pwm_data, exp_adr[cyc], exp_dat[cyc]);
                end
            end
        end
    end

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    function automatic int ramp(input int c, input int t, input int s);
        int d;
        d = (t > c) ? t - c : c - t;
        if (s == 0 || d <= s) return t;
        return (t > c) ? c + s : c - s;
    endfunction

    // Sweep whose first busy cycle follows edge s; returns the edge at which it is idle again.
    task automatic model_sweep(input int s, input bit force_w, output int end_e);
        int e;
        if (force_w) begin
            exp_wr[s] = 1'b1; exp_adr[s] = 0; exp_dat[s] = 0;
            e = s + 3;
        end else begin
            e = s + 1;
        end
        for (int ch = 0; ch < 3; ch++) begin
            int n;
            n = ramp(m_cur[ch], m_tgt[ch], m_step);
            if (n != m_cur[ch] || force_w) begin
                m_cur[ch] = n;
                exp_wr[e] = 1'b1; exp_adr[e] = 2 + 2 * ch; exp_dat[e] = n;
                e += 3;
            end else begin
                e += 1;
            end
        end
        end_e = e - 1;
        for (int c = s; c < end_e; c++) exp_busy[c] = 1'b1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin m_cur[i] = 0; m_tgt[i] = 0; end
        m_step = 1;
        exp_wr.delete(); exp_adr.delete(); exp_dat.delete(); exp_busy.delete();
        obs.delete();
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic cpu_write(input logic [3:0] a, input int v);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = 16'(v);
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic cpu_write_at(input int ed, input logic [3:0] a, input int v);
        if (cyc > ed - 1) begin
            total++; bad++;
            $display("FAIL sched got=%0d want=%0d", cyc, ed - 1);
        end
        wait_cyc(ed - 1);
        cpu_write(a, v);
    endtask

    task automatic set_reg(input logic [3:0] a, input int v);
        cpu_write(a, v);
        if (a == 4'h2 || a == 4'h4 || a == 4'h6) m_tgt[(a - 2) / 2] = v & 'h3FF;
        if (a == 4'h8) m_step = v & 'h3FF;
    endtask

    task automatic cpu_read(input logic [3:0] a, input int want, input string nm);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        chk(nm, int'(d_out), want);
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_dout", int'(d_out), 0);
        chk("rst_pwm", int'({pwm_cs, pwm_wr, pwm_addr, pwm_data, busy}), 0);
        model_reset();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
    endtask

    // Enable, let n ticks happen (optional kick on the first tick's edge), then disable.
    task automatic run_enabled(input int n, input bit kick);
        int p, t, last_end, d;
        p = cyc + 1;
        cpu_write(4'h0, 1);
        last_end = p;
        for (int k = 1; k <= n; k++) begin
            t = p + TD * k;
            if (k == 1 && kick) model_sweep((t > last_end ? t : last_end) + 1, 1'b1, last_end);
            model_sweep((t > last_end ? t : last_end) + 1, 1'b0, last_end);
        end
        if (kick) cpu_write_at(p + TD, 4'h0, 3);
        d = p + TD * n + 8;
        cpu_write_at(d, 4'h0, 0);
        wait_cyc((last_end > d ? last_end : d) + 4);
    endtask

    task automatic check_obs(input string nm, input int n);
        chk({nm, "_n"}, obs.size(), n);
        for (int i = 0; i < n; i++)
            if (i < obs.size()) chk(nm, obs[i], lit[i]);
        obs.delete();
    endtask

    initial begin
        int p, le;
        @(negedge clk);

        do_reset();
        set_reg(4'h8, 100);
        set_reg(4'h2, 300);
        run_enabled(4, 1'b0);
        lit = '{'h20064, 'h200C8, 'h2012C, 0, 0, 0, 0, 0};
        check_obs("s1_wr", 3);
        chk("s1_model_cur0", m_cur[0], 300);
        cpu_read(4'h2, 300, "s1_rd_cur0");

        do_reset();
        set_reg(4'h2, 1023);
        set_reg(4'h4, 5);
        set_reg(4'h6, 0);
        set_reg(4'h8, 10);
        run_enabled(2, 1'b0);
        lit = '{'h2000A, 'h40005, 'h20014, 0, 0, 0, 0, 0};
        check_obs("s2_wr", 3);
        cpu_read(4'h4, 5, "s2_rd_cur1");

        do_reset();
        set_reg(4'h8, 0);
        set_reg(4'h2, 300);
        run_enabled(1, 1'b0);
        set_reg(4'h2, 0);
        set_reg(4'h8, 128);
        run_enabled(3, 1'b0);
        set_reg(4'h8, 0);
        set_reg(4'h2, 777);
        run_enabled(2, 1'b0);
        lit = '{'h2012C, 'h200AC, 'h2002C, 'h20000, 'h20309, 0, 0, 0};
        check_obs("s3_wr", 5);
        cpu_read(4'h2, 777, "s3_rd_cur0");

        do_reset();
        set_reg(4'h8, 0);
        set_reg(4'h2, 50);
        set_reg(4'h4, 60);
        set_reg(4'h6, 70);
        run_enabled(1, 1'b0);
        run_enabled(2, 1'b1);
        lit = '{'h20032, 'h4003C, 'h60046, 'h00000, 'h20032, 'h4003C, 'h60046, 0};
        check_obs("s4_wr", 7);

        do_reset();
        set_reg(4'h2, 500);
        set_reg(4'h8, 100);
        p = cyc + 1;
        cpu_write(4'h0, 1);
        model_sweep(p + TD + 1, 1'b0, le);
        wait_cyc(p + TD + 2);
        #2;
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("s5_strobe_drop", int'({pwm_cs, pwm_wr, busy}), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        cpu_read(4'h2, 0, "s5_cur0");
        cpu_read(4'h4, 0, "s5_cur1");

        repeat (50) @(negedge clk);
        chk("s6_no_bus", obs.size(), 0);
        cpu_read(4'hA, 0, "s6_status");
        cpu_read(4'h8, 1, "s6_step_rst");
        cpu_read(4'h0, 0, "s6_rd_ctrl");
        cpu_write(4'h0, 1);
        cpu_read(4'hA, 1, "s6_status_en");
        cpu_write(4'h0, 0);
        p = cyc + 1;
        cpu_write(4'h0, 2);
        model_sweep(p + 1, 1'b1, le);
        cpu_read(4'hA, 4, "s6_status_kick");
        wait_cyc(le + 3);
        lit = '{'h00000, 'h20000, 'h40000, 'h60000, 0, 0, 0, 0};
        check_obs("s6_kick", 4);

        for (int ph = 0; ph < 10; ph++) begin
            set_reg(4'h2, int'($urandom_range(0, 65535)));
            set_reg(4'h4, int'($urandom_range(0, 65535)));
            set_reg(4'h6, int'($urandom_range(0, 65535)));
            set_reg(4'h8, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 300)));
            cpu_write(4'(4'hB + $urandom_range(0, 4)), int'($urandom_range(0, 65535)));
            run_enabled(int'($urandom_range(1, 5)), $urandom_range(0, 3) == 0);
            cpu_read(4'h2, m_cur[0], "rnd_cur0");
            cpu_read(4'h4, m_cur[1], "rnd_cur1");
            cpu_read(4'h6, m_cur[2], "rnd_cur2");
            cpu_read(4'h8, m_step, "rnd_step");
            cpu_read(4'hA, 0, "rnd_status");
            obs.delete();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        bad++;
        $display("FAIL watchdog got=timeout want=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
